cla_pipe_adder: RTL and testbench
=================================

// Module: cla_pipe_adder
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor. Splits WIDTH-bit
//  operands into WIDTH/BLOCK lookahead groups; one group resolved per pipeline
//  stage, group carry registered between stages. Valid/ready handshake on both
//  sides; full throughput (1 op/cycle) with back-pressure. Datapath arithmetic
//  primitive for wider ALU and accumulator blocks.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits; must be a multiple of BLOCK
//  BLOCK  4   lookahead group size (bits resolved per stage); >= 1
//  (derived) NSTG = WIDTH/BLOCK = pipeline depth = latency in cycles
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts beat this cycle
//  a          in   WIDTH  operand A (unsigned or two's complement)
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (ignored when sub=1)
//  sub        in   1      0: a+b+cin; 1: a-b (a + ~b + 1)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB (sub: 1 = no borrow, a >= b unsigned)
//  ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids 0, out_valid=0,
//    sum=0, cout=0, ovf=0; in_ready=1 in first cycle after reset release.
//  - Group logic per stage: p=a^b, g=a&b; carries c[i+1]=g[i]|(p[i]&c[i]) in full
//    lookahead form; sum bit = p[i]^c[i]. Group carry-out registered to next stage.
//  - Stage k resolves bits [k*BLOCK +: BLOCK]; unresolved upper operand bits and
//    resolved lower sum bits carried forward in stage registers (skew buffers).
//  - sub=1: b inverted and stage-0 carry-in forced 1 at entry; cin ignored.
//  - Stall = out_valid & ~out_ready. in_ready = ~stall. Whole pipeline advances
//    only when ~stall; when stalled all stage registers and outputs hold.
//  - Accept = in_valid & in_ready. Accepted beat appears on out_valid exactly NSTG
//    cycles later absent stalls; each stall cycle adds one. Order preserved.
//  - Bubbles (no accept) propagate as invalid stages; no compaction. in_ready does
//    not depend on in_valid (no combinational in->out path besides out_ready).
//  - sum/cout/ovf registered, stable while out_valid & ~out_ready.
//  - ovf computed from MSB-group internal carry; meaningful for signed use only.
//  - Reset mid-operation: all in-flight beats discarded, no partial result emitted.
//  - Width rules: no truncation; WIDTH+1-bit true result = {cout,sum} for add.
// TESTING (WIDTH=16, BLOCK=4, latency 4)
//  1 Reset: assert rst -> out_valid=0,sum=0,cout=0,ovf=0; release -> in_ready=1.
//  2 Add a=FFFF b=0001 cin=0 sub=0, out_ready=1 -> 4 cycles later sum=0000 cout=1 ovf=0.
//  3 Add a=7FFF b=0001 cin=0 -> sum=8000 cout=0 ovf=1; a=1234 b=4321 cin=1 -> 5556 c0 v0.
//  4 Sub a=0003 b=0005 cin=1 -> sum=FFFE cout=0 ovf=0; a=8000 b=0001 -> 7FFF cout=1 ovf=1.
//  5 Stream 6 beats back-to-back, drop out_ready 2 cycles at first result -> in_ready=0
//    and outputs frozen for those cycles; all 6 results in order, none lost/duplicated.
//  6 Accept 2 beats, assert rst for 1 cycle at cycle 2 -> out_valid stays 0, no result;
//    random add/sub regression (1e4 beats, random out_ready) vs behavioural model.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one BLOCK-bit lookahead group resolved per stage.
// Latency WIDTH/BLOCK cycles from accept to out_valid, plus one cycle per stall cycle; 1 op/cycle.
// Backpressure: out_valid & ~out_ready freezes the whole pipeline and drops in_ready the same cycle.
//
// Ports:
//   clk, rst             rising-edge clock; asynchronous active-high reset (release synchronously)
//   in_valid / in_ready  operand beat handshake; in_ready depends only on out_valid and out_ready
//   a, b, cin, sub       operands; sub=1 computes a - b (a + ~b + 1) and ignores cin
//   out_valid/out_ready  result handshake
//   sum, cout, ovf       registered result, carry out of the MSB, signed overflow
//
// Structure: stage 0 resolves group 0 straight from the input operands, so the first
// pipeline register already holds group-0 sum bits. Stage k works on a register pair:
//   x : bits below k*BLOCK hold resolved sum bits, bits at and above hold operand A
//   y : only the still-unresolved bits of the (possibly inverted) operand B
// The y register shrinks by BLOCK bits per stage, so no dead bits are carried.
// The last stage writes the output registers directly.

module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // WIDTH must be a multiple of BLOCK; the stage count is the pipeline depth.
    localparam int NSTG = WIDTH / BLOCK;

    logic stall;
    logic accept;

    // The only combinational path from an input to an output is out_ready -> in_ready.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    // Full lookahead carries for one group, written as the flat sum-of-products
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]ci rather than as a ripple chain.
    // Returned vector: [0] = group carry-in, [BLOCK] = group carry-out.
    function automatic logic [BLOCK:0] lookahead(
        input logic [BLOCK-1:0] p,
        input logic [BLOCK-1:0] g,
        input logic             ci
    );
        logic [BLOCK:0] c;
        logic           term;
        logic           pchain;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            term   = g[i];
            pchain = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term   = term | (pchain & g[j]);
                pchain = pchain & p[j];
            end
            c[i+1] = term | (pchain & ci);
        end
        return c;
    endfunction

    for (genvar k = 0; k < NSTG; k++) begin : stg
        localparam int LO  = k * BLOCK;     // first bit resolved by this stage
        localparam int REM = WIDTH - LO;    // operand-B bits still unresolved here

        logic [WIDTH-1:0] x;     // resolved sum bits below LO, operand A from LO up
        logic [REM-1:0]   y;     // unresolved operand-B bits, LSB aligned to LO
        logic             c;     // carry into bit LO
        logic             v;     // this stage holds a live beat

        logic [BLOCK-1:0] gp;
        logic [BLOCK-1:0] gg;
        logic [BLOCK:0]   gc;
        logic [WIDTH-1:0] nx;    // x with this stage's group replaced by sum bits

        if (k == 0) begin : entry
            // Subtraction is folded in here: invert B and force the carry-in to 1.
            assign x = a;
            assign y = sub ? ~b : b;
            assign c = sub | cin;
            assign v = accept;
        end else begin : regs
            // Bubbles travel through as v=0; the datapath is loaded regardless so
            // that only the valid bit needs to be trusted downstream.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    x <= '0;
                    y <= '0;
                    c <= 1'b0;
                    v <= 1'b0;
                end else if (!stall) begin
                    x <= stg[k-1].nx;
                    y <= stg[k-1].y[REM+BLOCK-1:BLOCK];
                    c <= stg[k-1].gc[BLOCK];
                    v <= stg[k-1].v;
                end
            end
        end

        assign gp = x[LO +: BLOCK] ^ y[BLOCK-1:0];
        assign gg = x[LO +: BLOCK] & y[BLOCK-1:0];
        assign gc = lookahead(gp, gg, c);

        always_comb begin
            nx               = x;
            nx[LO +: BLOCK]  = gp ^ gc[BLOCK-1:0];
        end

        if (k == NSTG - 1) begin : tail
            // Result registers only load on a live beat so that sum/cout/ovf stay
            // put across bubbles as well as across stalls.
            // Overflow is the carry into the MSB xor the carry out of it, both of
            // which are internal carries of this final group.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                end else if (!stall) begin
                    out_valid <= v;
                    if (v) begin
                        sum  <= nx;
                        cout <= gc[BLOCK];
                        ovf  <= gc[BLOCK] ^ gc[BLOCK-1];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and randomised checks of cla_pipe_adder (WIDTH=16, BLOCK=4, latency 4).
// Inputs are driven 1ns after the rising edge and outputs sampled 2ns after it.
// Random traffic is scored against an arithmetic model held in a queue.

module tb_cla_pipe_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {cout, ovf, sum} computed with 17-bit arithmetic and the
    // operand-sign overflow rule.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic s);
        logic [16:0] r;
        logic [15:0] yy;
        logic        c0;
        logic        v;
        yy = s ? ~y : y;
        c0 = s ? 1'b1 : ci;
        r  = {1'b0, x} + {1'b0, yy} + {16'b0, c0};
        v  = (x[15] == yy[15]) && (r[15] != x[15]);
        return {r[16], v, r[15:0]};
    endfunction

    // One isolated beat: checks acceptance, absence of output for 3 cycles,
    // the result in the 4th cycle, and that it is consumed exactly once.
    task automatic single(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vcin, input logic vsub,
                          input logic [15:0] es, input logic ec, input logic ev);
        a = va; b = vb; cin = vcin; sub = vsub;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, " in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1;
            chk({tag, " early out_valid"}, out_valid, 0);
            tick();
        end
        #1;
        chk({tag, " out_valid"}, out_valid, 1);
        chk({tag, " sum"}, sum, es);
        chk({tag, " cout"}, cout, ec);
        chk({tag, " ovf"}, ovf, ev);
        tick();
        #1;
        chk({tag, " consumed"}, out_valid, 0);
    endtask

    logic [15:0] exp_s [6];
    logic [17:0] q [$];
    int rcv;
    int idx;
    int sent;
    int got;
    int cyc;

    initial begin
        exp_s = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005};

        // Reset state
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset out_valid", out_valid, 0);
        chk("reset sum", sum, 0);
        chk("reset cout", cout, 0);
        chk("reset ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        #1;
        chk("post-reset in_ready", in_ready, 1);

        // Directed single beats
        single("add ffff+1",       16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        single("add 7fff+1",       16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        single("add 1234+4321+1",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        single("sub 3-5",          16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        single("sub 8000-1",       16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        single("sub 5-3",          16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        single("add 8000+8000",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        single("add 00ff+1+1",     16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);

        // Six back-to-back beats, out_ready dropped for the first two result cycles
        rcv = 0;
        idx = 0;
        for (int cy = 0; cy < 24; cy++) begin
            out_ready = !(cy == 4 || cy == 5);
            in_valid  = (idx < 6);
            a = 16'h0FFF; b = 16'(idx + 1); cin = 1'b0; sub = 1'b0;
            #1;
            if (cy == 4 || cy == 5) begin
                chk("stall in_ready", in_ready, 0);
                chk("stall out_valid", out_valid, 1);
                chk("stall sum frozen", sum, 16'h1000);
            end
            if (out_valid && out_ready) begin
                if (rcv < 6) chk("stream result", {cout, ovf, sum}, {2'b00, exp_s[rcv]});
                rcv++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        chk("stream results count", rcv, 6);
        chk("stream accepted count", idx, 6);

        // Reset while two beats are in flight
        out_ready = 1'b1;
        in_valid = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid reset out_valid", out_valid, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("no result after reset", out_valid, 0);
            tick();
        end

        // Random add/sub regression with random back-pressure
        sent = 0;
        got  = 0;
        cyc  = 0;
        while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
            in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = (sent >= 10000) || ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() > 0) chk("random result", {cout, ovf, sum}, q.pop_front());
                else chk("random unexpected out_valid", out_valid, 0);
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin, sub));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("random queue drained", q.size(), 0);
        chk("random results count", got, 10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
